// File: rtl/demux_scan_ctrl.sv
// Serialises one 8-bit word onto a 1:8 demux: a/s/en are valid from the accepting edge (0 cycles); done comes 8*DWELL edges later.
// Backpressure: in_ready is high only in IDLE. Defining DEMUX_SKIP_ZERO_EN makes the scan skip channels whose bit is 0.
module demux_scan_ctrl #(
  parameter int DWELL = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       abort,
  output logic       a,
  output logic [2:0] s,
  output logic       en,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] s_q, s_d;
  logic       a_q, a_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

`ifdef DEMUX_SKIP_ZERO_EN
  logic [7:0] above;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction
`endif

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dwell_d = dwell_q;
    s_d     = s_q;
    a_d     = a_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DEMUX_SKIP_ZERO_EN
    // Set bits strictly above the channel currently presented.
    above   = shift_q & (8'hFE << s_q);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          dwell_d = 8'd0;
`ifdef DEMUX_SKIP_ZERO_EN
          if (in_data == 8'd0) begin
            done_d = 1'b1;
          end else begin
            s_d     = lowest_set(in_data);
            a_d     = 1'b1;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = SCAN;
          end
`else
          s_d     = 3'd0;
          a_d     = in_data[0];
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          dwell_d = 8'd0;
          s_d     = 3'd0;
          a_d     = 1'b0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
`ifdef DEMUX_SKIP_ZERO_EN
          if (above != 8'd0) begin
            s_d = lowest_set(above);
            a_d = 1'b1;
          end else begin
`else
          if (s_q != 3'd7) begin
            s_d = s_q + 3'd1;
            a_d = shift_q[s_q + 3'd1];
          end else begin
`endif
            state_d = IDLE;
            s_d     = 3'd0;
            a_d     = 1'b0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      dwell_q <= 8'd0;
      s_q     <= 3'd0;
      a_q     <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dwell_q <= dwell_d;
      s_q     <= s_d;
      a_q     <= a_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a    = a_q;
  assign s    = s_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Bench for demux_scan_ctrl: frame table, corner-case sequences, and random traffic against a presentation-list model.
module tb_demux_scan_ctrl;

  localparam int DWELL = 3;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       abort;
  logic       a;
  logic [2:0] s;
  logic       en;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // One entry per cycle of a frame: {channel, data bit}.
  logic [3:0] tr[$];
  logic [3:0] mq[$];

  typedef struct {
    logic [7:0] data;
    int         len;
    logic [2:0] first_s;
    int         ones;
  } vec_t;

  vec_t tbl[6];

  demux_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .a(a), .s(s), .en(en), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic make_trace(input logic [7:0] d);
    tr.delete();
    for (int ch = 0; ch < 8; ch++) begin
`ifdef DEMUX_SKIP_ZERO_EN
      if (!d[ch]) continue;
`endif
      for (int r = 0; r < DWELL; r++) tr.push_back({3'(ch), d[ch]});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int cycles, en_cnt, ones;
    in_data  = v.data;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (v.len > 0) chk("first_s", {29'd0, s}, {29'd0, v.first_s});
    cycles = 0; en_cnt = 0; ones = 0;
    while (done !== 1'b1 && cycles < 300) begin
      if (en === 1'b1) en_cnt++;
      if (en === 1'b1 && a === 1'b1) ones++;
      if (busy !== en || in_ready !== !en) begin
        chk("flags", {29'd0, busy, en, in_ready}, {29'd0, en, en, !en});
      end
      step();
      cycles++;
    end
    chk("done_lat", cycles, v.len);
    chk("en_cycles", en_cnt, v.len);
    chk("a_ones", ones, v.ones);
    chk("done_cycle", {29'd0, en, busy, in_ready}, 32'd1);
    step();
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic       exp_done, exp_en;
    logic [2:0] exp_s;
    logic       exp_a;
    int         n, cnt, ones;

`ifdef DEMUX_SKIP_ZERO_EN
    tbl[0] = '{8'hA5, 4*DWELL, 3'd0, 4*DWELL};
    tbl[1] = '{8'hFF, 8*DWELL, 3'd0, 8*DWELL};
    tbl[2] = '{8'h00, 0,       3'd0, 0};
    tbl[3] = '{8'h81, 2*DWELL, 3'd0, 2*DWELL};
    tbl[4] = '{8'h80, 1*DWELL, 3'd7, 1*DWELL};
    tbl[5] = '{8'h3C, 4*DWELL, 3'd2, 4*DWELL};
`else
    tbl[0] = '{8'hA5, 8*DWELL, 3'd0, 4*DWELL};
    tbl[1] = '{8'hFF, 8*DWELL, 3'd0, 8*DWELL};
    tbl[2] = '{8'h00, 8*DWELL, 3'd0, 0};
    tbl[3] = '{8'h81, 8*DWELL, 3'd0, 2*DWELL};
    tbl[4] = '{8'h80, 8*DWELL, 3'd0, 1*DWELL};
    tbl[5] = '{8'h3C, 8*DWELL, 3'd0, 4*DWELL};
`endif

    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; abort = 1'b0;
    #12;
    chk("reset_out", {27'd0, s, a, en, busy, done}, 32'd0);
    chk("reset_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset", {27'd0, s, a, en, busy, done}, 32'd0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Channel-by-channel trace of A5 while a competing word is offered.
    make_trace(8'hA5);
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_data = 8'h3C;
    chk("accept_sa", {28'd0, s, a}, {28'd0, tr[0]});
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("busy_rdy", {31'd0, in_ready}, 32'd0);
      chk("busy_sa", {28'd0, s, a}, {28'd0, tr[i]});
    end
    in_valid = 1'b0;
    wait_idle();
    step();

    // Abort at s=4, dwell count 1.
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4*DWELL + 1; i++) step();
    chk("abort_pre_s", {29'd0, s}, 32'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_out", {27'd0, s, a, en, busy, done}, 32'd0);
    chk("abort_rdy", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) cnt++;
      step();
    end
    chk("abort_nodone", cnt, 0);

    // Asynchronous reset mid-frame.
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5*DWELL; i++) step();
    chk("rst_pre_s", {29'd0, s}, 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {27'd0, s, a, en, busy, done}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    in_data = 8'h01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst_new", {27'd0, s, a, en, busy}, {27'd0, 3'd0, 1'b1, 1'b1, 1'b1});
    wait_idle();
    step();

`ifndef DEMUX_SKIP_ZERO_EN
    // Back-to-back frames with in_valid held high.
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_data = 8'h00;
    for (int i = 0; i < 8*DWELL; i++) step();
    chk("b2b_done", {28'd0, done, en, in_ready, busy}, 32'b1010);
    step();
    in_valid = 1'b0;
    chk("b2b_start", {27'd0, s, a, en, busy}, {27'd0, 3'd0, 1'b0, 1'b1, 1'b1});
    cnt = 0; ones = 0;
    for (int i = 0; i < 8*DWELL; i++) begin
      if (en === 1'b1) cnt++;
      if (a === 1'b1) ones++;
      if (i < 8*DWELL - 1) step();
    end
    chk("b2b_en", cnt, 8*DWELL);
    chk("b2b_a0", ones, 0);
    step();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    step();
`endif

    // Random traffic against the presentation-list model.
    mq.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      abort    = ($urandom_range(0, 50) == 0);
      exp_done = 1'b0;
      if (mq.size() != 0) begin
        if (abort) mq.delete();
        else begin
          void'(mq.pop_front());
          if (mq.size() == 0) exp_done = 1'b1;
        end
      end else if (in_valid) begin
        make_trace(in_data);
        mq = tr;
        if (mq.size() == 0) exp_done = 1'b1;
      end
      step();
      exp_en = (mq.size() != 0);
      exp_s  = exp_en ? mq[0][3:1] : 3'd0;
      exp_a  = exp_en ? mq[0][0] : 1'b0;
      chk("rand", {24'd0, in_ready, busy, en, done, s, a},
          {24'd0, !exp_en, exp_en, exp_en, exp_done, exp_s, exp_a});
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    n = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_scan_ctrl.md
Name: demux_scan_ctrl

Overview:
- Upstream sequencer for the 1:8 demultiplexer. Accepts one 8-bit word through a valid/ready handshake and serialises it onto the demux data input `a`.
- Steps the 3-bit select `s` through channels 0..7 and holds each channel for DWELL clock cycles.
- Flags the active period with `en`/`busy` and pulses `done` at the end of the frame.

Parameters:
- DWELL, 3: clock cycles each channel is presented; legal range 1..255.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word; high only in IDLE.
- in_data, input, 8: word to serialise; bit i is routed to channel i.
- abort, input, 1: synchronous frame cancel.
- a, output, 1: serial data bit for the demux data input.
- s, output, 3: channel select for the demux.
- en, output, 1: a/s are a valid channel presentation.
- busy, output, 1: frame in progress (state SCAN).
- done, output, 1: one-cycle pulse after the last channel completes.

Behaviour:
- rst_n low, asynchronous: state=IDLE, shift_reg=0, dwell_cnt=0, s=0, a=0, en=0, busy=0, done=0.
- in_ready decodes combinationally from state, so it reads 1 during reset. in_valid is ignored while rst_n is low.
- All outputs except in_ready are registered.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge k: latch in_data into shift_reg; s=0, a=in_data[0], en=1, busy=1, dwell_cnt=0; go to SCAN.
  - a/s/en are valid from edge k, so latency is 0 cycles after the accepting edge.
- SCAN:
  - in_ready=0; in_valid is ignored and no word is latched.
  - dwell_cnt increments each cycle.
  - When dwell_cnt==DWELL-1 and s<7: s=s+1, a=shift_reg[s+1], dwell_cnt=0.
  - When dwell_cnt==DWELL-1 and s==7: go to IDLE; en=0, busy=0, a=0, s=0; done=1 for exactly one cycle.
- Frame length: 8*DWELL cycles of en=1. done asserts on the edge 8*DWELL cycles after the accepting edge.
- Back-to-back frames: the cycle in which done=1 is already IDLE with in_ready=1. A new word may be accepted in that same cycle, giving zero idle cycles between frames.
- abort:
  - In SCAN: next edge forces IDLE, en=0, busy=0, a=0, s=0, dwell_cnt=0; done is NOT pulsed.
  - In IDLE: no effect. If abort and in_valid are both high in IDLE, the word is accepted.
- abort has priority over normal stepping in SCAN, including on the final dwell cycle of channel 7.
- a changes only together with s, so the demux never sees a data change mid-channel.
- DWELL=1: s advances every cycle; a frame lasts 8 cycles.

Optional Feature:
- Macro: DEMUX_SKIP_ZERO_EN.
- Defined: channels whose bit is 0 are never presented.
  - On accept, s is the lowest index with a set bit and a=1.
  - Each step jumps to the next higher set bit.
  - After the highest set bit's dwell, done pulses and the block returns to IDLE.
  - in_data=0: accept → next edge done=1, state stays IDLE, en never asserts, busy stays 0.
- Undefined: all 8 channels are presented in order, as in Behaviour.

Test Plan:
- DWELL=3, in_data=8'hA5, pulse in_valid one cycle → s steps 0..7, 3 cycles each; a = 1,0,1,0,0,1,0,1; en/busy high for 24 cycles; done pulses exactly once, 24 cycles after accept.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 → second word accepted in the done cycle; s restarts at 0 with no gap; a=0 for all 24 cycles of frame 2.
- Busy rejection: during a frame, drive in_valid=1 with 8'h3C → in_ready=0, the word is not latched, and the current frame's a/s sequence is unchanged.
- abort asserted at s=4, dwell_cnt=1 → next edge s=0, a=0, en=0, busy=0; done never pulses; in_ready=1 the same cycle.
- Reset mid-frame: rst_n low at s=5 → outputs clear immediately, without waiting for a clock edge; after release, a new word 8'h01 starts at s=0 with a=1.
- DEMUX_SKIP_ZERO_EN defined, DWELL=3:
  - in_data=8'h81 → s=0 for 3 cycles, then s=7 for 3 cycles, a=1 throughout, done 6 cycles after accept.
  - in_data=8'h00 → done one cycle after accept, en stays 0.
